// File: rtl/demux1_8_deser_if.sv
// Serial-in / byte-out handshake bundle for the 1:8 deserializer.
// The master drives serial bits and consumes bytes; the slave is the deserializer.
interface demux1_8_deser_if;
  logic       D;
  logic       D_VALID;
  logic       D_READY;
  logic       SYNC;
  logic [7:0] O;
  logic       O_VALID;
  logic       O_READY;
  logic [2:0] S;

  modport master (
    output D, D_VALID, SYNC, O_READY,
    input  D_READY, O, O_VALID, S
  );

  modport slave (
    input  D, D_VALID, SYNC, O_READY,
    output D_READY, O, O_VALID, S
  );
endinterface

// File: rtl/demux1_8_deser.sv
// 1:8 registered demultiplexer: routes serial bits into a byte buffer via a
// 3-bit select pointer and presents each completed byte on a valid/ready port.
module demux1_8_deser #(
  parameter bit MSB_FIRST = 1'b0
) (
  input logic               clk,
  input logic               rst,
  demux1_8_deser_if.slave   bus
);

  logic [7:0] buf_p0;
  logic [2:0] ptr_p0;
  logic [7:0] o_p1;
  logic       vld_p1;

  logic       accept;
  logic       complete;
  logic [2:0] pos;
  logic [7:0] buf_next;

  // Only the completing bit can be held off by a pending, unconsumed byte.
  assign bus.D_READY = !bus.SYNC && ((ptr_p0 != 3'd7) || !vld_p1 || bus.O_READY);
  assign accept      = bus.D_VALID && bus.D_READY;
  assign complete    = accept && (ptr_p0 == 3'd7);
  assign pos         = MSB_FIRST ? (3'd7 - ptr_p0) : ptr_p0;

  always_comb begin
    buf_next      = buf_p0;
    buf_next[pos] = bus.D;
  end

  // Stage p0 collects bits; stage p1 holds the finished byte for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_p0 <= 8'h00;
      ptr_p0 <= 3'd0;
      o_p1   <= 8'h00;
      vld_p1 <= 1'b0;
    end else begin
      if (vld_p1 && bus.O_READY)
        vld_p1 <= 1'b0;

      if (bus.SYNC) begin
        buf_p0 <= 8'h00;
        ptr_p0 <= 3'd0;
      end else if (complete) begin
        // A completion on the same edge as a consume overrides the clear above.
        o_p1   <= buf_next;
        vld_p1 <= 1'b1;
        buf_p0 <= 8'h00;
        ptr_p0 <= 3'd0;
      end else if (accept) begin
        buf_p0 <= buf_next;
        ptr_p0 <= ptr_p0 + 3'd1;
      end
    end
  end

  assign bus.O       = o_p1;
  assign bus.O_VALID = vld_p1;
  assign bus.S       = ptr_p0;

endmodule

// File: tb/tb_demux1_8_deser.sv
// Bench for demux1_8_deser: both bit orders driven in lockstep and compared
// each cycle against a queue-based byte assembly model, plus directed scenarios.
module tb_demux1_8_deser;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  demux1_8_deser_if bus0 ();
  demux1_8_deser_if bus1 ();

  demux1_8_deser #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  demux1_8_deser #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_vec  = 0;
  int n_fail = 0;

  // Reference: bits accepted so far in the current byte, in arrival order.
  bit       m_bits[$];
  bit [7:0] m_o_lsb;
  bit [7:0] m_o_msb;
  bit       m_v;
  bit       m_known = 1'b0;
  bit       last_acc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic d, input logic dv, input logic sy, input logic ordy, input logic r);
    bit rdy;
    bit [7:0] v_lsb;
    bit [7:0] v_msb;
    bus0.D = d; bus0.D_VALID = dv; bus0.SYNC = sy; bus0.O_READY = ordy;
    bus1.D = d; bus1.D_VALID = dv; bus1.SYNC = sy; bus1.O_READY = ordy;
    rst = r;
    #8;
    rdy = !sy && (m_bits.size() != 7 || !m_v || ordy);
    if (m_known) begin
      check_val("rdy0", 32'(bus0.D_READY), 32'(rdy));
      check_val("rdy1", 32'(bus1.D_READY), 32'(rdy));
      check_val("o0",   32'(bus0.O),       32'(m_o_lsb));
      check_val("o1",   32'(bus1.O),       32'(m_o_msb));
      check_val("ov0",  32'(bus0.O_VALID), 32'(m_v));
      check_val("ov1",  32'(bus1.O_VALID), 32'(m_v));
      check_val("s0",   32'(bus0.S),       32'(m_bits.size()));
      check_val("s1",   32'(bus1.S),       32'(m_bits.size()));
    end
    last_acc = dv && rdy && !r;
    if (r) begin
      m_bits.delete();
      m_o_lsb = 8'h00;
      m_o_msb = 8'h00;
      m_v     = 1'b0;
      m_known = 1'b1;
    end else begin
      if (m_v && ordy) m_v = 1'b0;
      if (sy) begin
        m_bits.delete();
      end else if (last_acc) begin
        m_bits.push_back(d);
        if (m_bits.size() == 8) begin
          v_lsb = 8'h00;
          v_msb = 8'h00;
          for (int i = 0; i < 8; i++) begin
            v_lsb[i]     = m_bits[i];
            v_msb[7 - i] = m_bits[i];
          end
          m_o_lsb = v_lsb;
          m_o_msb = v_msb;
          m_v     = 1'b1;
          m_bits.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Offers one bit until it is accepted; an overrun bound counts as a failure.
  task automatic send_bit(input logic d, input logic ordy);
    for (int k = 0; k < 40; k++) begin
      step(d, 1'b1, 1'b0, ordy, 1'b0);
      if (last_acc) return;
    end
    check_val("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] val, input int nbits, input logic ordy);
    for (int i = 0; i < nbits; i++) send_bit(val[i], ordy);
  endtask

  initial begin
    rst = 1'b1;
    bus0.D = 1'b0; bus0.D_VALID = 1'b0; bus0.SYNC = 1'b0; bus0.O_READY = 1'b0;
    bus1.D = 1'b0; bus1.D_VALID = 1'b0; bus1.SYNC = 1'b0; bus1.O_READY = 1'b0;
    @(posedge clk);
    #1;

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("rst_o",   32'(bus0.O),       32'h00);
    check_val("rst_ov",  32'(bus0.O_VALID), 32'h0);
    check_val("rst_s",   32'(bus0.S),       32'h0);

    // Bits 1,0,1,1,0,0,1,0 first to last: 8'h4D LSB-first, 8'hB2 MSB-first.
    send_byte(8'b0100_1101, 8, 1'b1);
    check_val("t1_o_lsb", 32'(bus0.O), 32'h4D);
    check_val("t1_o_msb", 32'(bus1.O), 32'hB2);
    check_val("t1_ov",    32'(bus0.O_VALID), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("t1_ov_clr", 32'(bus0.O_VALID), 32'h0);

    // Backpressure: byte A5 pending, seven bits of 3C accepted, 8th stalls.
    send_byte(8'hA5, 8, 1'b0);
    send_byte(8'h3C, 7, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("t3_hold_o", 32'(bus0.O), 32'hA5);
    check_val("t3_hold_s", 32'(bus0.S), 32'h7);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("t3_new_o",  32'(bus0.O), 32'h3C);
    check_val("t3_new_ov", 32'(bus0.O_VALID), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Realign mid-byte; the bit offered during SYNC is dropped.
    send_byte(8'h07, 3, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_val("t4_s0", 32'(bus0.S), 32'h0);
    send_byte(8'hF0, 8, 1'b1);
    check_val("t4_o", 32'(bus0.O), 32'hF0);

    // Gaps between every bit.
    for (int i = 0; i < 8; i++) begin
      send_bit(((8'h81 >> i) & 8'h1) != 0, 1'b1);
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check_val("t5_o", 32'(bus0.O), 32'h81);

    // Reset with a partial byte and a pending byte.
    send_byte(8'h77, 8, 1'b0);
    send_byte(8'h00, 5, 1'b0);
    check_val("t6_s5", 32'(bus0.S), 32'h5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("t6_o",  32'(bus0.O),       32'h00);
    check_val("t6_ov", 32'(bus0.O_VALID), 32'h0);
    check_val("t6_s",  32'(bus0.S),       32'h0);
    send_byte(8'h55, 8, 1'b1);
    check_val("t6_o55", 32'(bus0.O), 32'h55);

    // Randomized traffic with occasional realign and reset.
    for (int c = 0; c < 3000; c++) begin
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 399) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
